pio_edge_service_ctrl: RTL and testbench
========================================

// Module: pio_edge_service_ctrl
// PURPOSE
//   Hardware servicer for the edge-capturing switch PIO (10-bit in_port, regs: 0=data, 2=irq_mask, 3=edge_capture).
//   Drives the PIO slave port directly: programs irq_mask, and on each irq reads edge_capture and data, clears capture,
//   then hands one event {edges, level} to a downstream consumer via valid/ready. Replaces the CPU ISR for switch input.
// PARAMETERS
//   WIDTH       10       PIO input width (bits of irq_mask/edge_capture/data used)
//   MASK_RST    10'h3FF  irq_mask value programmed after reset
// PORTS
//   clk            in   1      system clock; single clock domain
//   reset          in   1      synchronous, active-high reset
//   cfg_mask       in   WIDTH  new irq_mask value
//   cfg_load       in   1      1-cycle pulse: request irq_mask reprogram with cfg_mask
//   pio_irq        in   1      PIO irq output
//   pio_address    out  2      PIO register address
//   pio_chipselect out  1      PIO chipselect
//   pio_write_n    out  1      PIO write strobe, active low
//   pio_writedata  out  32     PIO write data
//   pio_readdata   in   32     PIO readdata (registered in PIO: valid 1 cycle after address presented)
//   evt_valid      out  1      event available
//   evt_ready      in   1      consumer accepts event when evt_valid & evt_ready
//   evt_edges      out  WIDTH  edge_capture snapshot (bits that toggled)
//   evt_level      out  WIDTH  data snapshot (switch levels after edge)
//   busy           out  1      high in any state except IDLE
// BEHAVIOUR
//   Reset: state=INIT; pio_chipselect=0, pio_write_n=1, pio_address=0, pio_writedata=0, evt_valid=0, evt_edges=0,
//     evt_level=0, load_pend=0, mask_shadow=MASK_RST. Reset mid-transaction abandons it; no partial event emitted.
//   All outputs registered. States and transitions (one cycle each unless noted):
//   INIT     : cs=1, write_n=0, addr=2, wdata={0,mask_shadow} -> CLR0 (also clears stale captures)
//   CLR0     : cs=1, write_n=0, addr=3, wdata=0 -> SETTLE
//   IDLE     : cs=0. load_pend -> INIT (mask_shadow<=cfg_mask latched at pulse); else pio_irq -> RDCAP; else stay
//   RDCAP    : addr=3, cs=1, write_n=1 -> RDCAP_W
//   RDCAP_W  : cap<=pio_readdata[WIDTH-1:0]; addr=0 -> RDDAT
//   RDDAT    : addr=0 held -> RDDAT_W;  RDDAT_W: lvl<=pio_readdata[WIDTH-1:0] -> CLR
//   CLR      : write addr=3 (any data clears all bits) -> PUSH if cap!=0, else SETTLE (spurious irq, no event)
//   PUSH     : evt_valid=1, evt_edges=cap, evt_level=lvl held stable until evt_ready; on handshake -> SETTLE
//   SETTLE   : cs=0; ignore pio_irq this cycle (PIO irq lags clear by 1 cycle) -> IDLE
//   Latency: irq seen in IDLE at cycle N -> evt_valid at N+6 (RDCAP,RDCAP_W,RDDAT,RDDAT_W,CLR,PUSH).
//   cfg_load: sets load_pend, latches cfg_mask; repeated pulse before service overwrites (last wins).
//     cfg_load concurrent with irq in IDLE: mask reprogram first (INIT->CLR0 discards pending captures by design).
//   Edges landing between RDCAP_W and CLR are lost (PIO clear is all-bits); documented limitation.
//   Backpressure: while in PUSH no PIO access; new edges accumulate in PIO edge_capture, serviced next pass.
//   pio_writedata upper bits [31:WIDTH] always 0.
// STRUCTURE
//   Shared pkg (pio_ctrl_pkg): state encoding localparams, PIO offsets PIO_DATA=0, PIO_MASK=2, PIO_EDGE=3.
//   Single module; no sub-module (FSM + 3 WIDTH-bit regs + load_pend flag).
// TESTING (bench instantiates real PIO model with in_port driven)
//   Reset release -> write addr2=0x3FF then addr3 write; busy low by cycle 3; evt_valid stays 0.
//   in_port 0x000->0x005, evt_ready=1 -> one event edges=0x005, level=0x005; irq deasserts; back in IDLE.
//   Event pending with evt_ready=0 for 20 cycles, toggle bit 9 meanwhile -> first event held stable;
//     after accept, second event edges=0x200.
//   cfg_load with cfg_mask=0x001, then toggle bit 4 -> no event; toggle bit 0 -> edges=0x001 (capture shows 0x001).
//   Force pio_irq high with edge_capture=0 (spurious) -> CLR write occurs, no evt_valid, returns IDLE.
//   Assert reset during RDDAT -> all outputs to reset values next cycle; INIT sequence replays; no stray event.

Source files
------------

// File: rtl/pio_ctrl_pkg.sv
// Shared definitions for the edge-capture PIO servicer: FSM encoding and PIO register offsets.
package pio_ctrl_pkg;

  typedef enum logic [3:0] {
    StInit   = 4'd0,
    StClr0   = 4'd1,
    StIdle   = 4'd2,
    StRdCap  = 4'd3,
    StRdCapW = 4'd4,
    StRdDat  = 4'd5,
    StRdDatW = 4'd6,
    StClr    = 4'd7,
    StPush   = 4'd8,
    StSettle = 4'd9
  } state_e;

  localparam logic [1:0] PIO_DATA = 2'd0;
  localparam logic [1:0] PIO_MASK = 2'd2;
  localparam logic [1:0] PIO_EDGE = 2'd3;

endpackage

// File: rtl/pio_edge_service_ctrl.sv
// Hardware replacement for the switch-PIO ISR: programs irq_mask, services edge irqs and
// hands {edges, level} events downstream over valid/ready.
module pio_edge_service_ctrl
  import pio_ctrl_pkg::*;
#(
  parameter int unsigned      WIDTH    = 10,
  parameter logic [WIDTH-1:0] MASK_RST = 10'h3FF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic             cfg_load,
  input  logic             pio_irq,
  output logic [1:0]       pio_address,
  output logic             pio_chipselect,
  output logic             pio_write_n,
  output logic [31:0]      pio_writedata,
  input  logic [31:0]      pio_readdata,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_edges,
  output logic [WIDTH-1:0] evt_level,
  output logic             busy
);

  state_e           state_q, state_d;
  logic             load_pend_q, load_pend_d;
  logic [WIDTH-1:0] mask_shadow_q, cap_q, lvl_q;
  logic             evt_valid_q, busy_q;
  logic             cs_q, wn_q;
  logic [1:0]       addr_q;
  logic [31:0]      wdata_q;

  logic             bus_cs, bus_wn;
  logic [1:0]       bus_addr;
  logic [31:0]      bus_wdata;

  logic             unused_rdata;
  assign unused_rdata = ^pio_readdata[31:WIDTH];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInit:   state_d = StClr0;
      StClr0:   state_d = StSettle;
      StIdle: begin
        // Mask reprogram wins over a concurrent irq; the INIT/CLR0 pass drops stale captures.
        if (load_pend_q || cfg_load) state_d = StInit;
        else if (pio_irq)            state_d = StRdCap;
      end
      StRdCap:  state_d = StRdCapW;
      StRdCapW: state_d = StRdDat;
      StRdDat:  state_d = StRdDatW;
      StRdDatW: state_d = StClr;
      StClr:    state_d = (|cap_q) ? StPush : StSettle;
      StPush:   if (evt_ready) state_d = StSettle;
      StSettle: state_d = StIdle;
      default:  state_d = StInit;
    endcase
  end

  assign load_pend_d = (state_q == StIdle) ? 1'b0 : (load_pend_q | cfg_load);

  // INIT/CLR0 writes issue from the current state so the mask write follows reset release;
  // read commands issue for the state being entered so readdata lands in the *_W states.
  always_comb begin
    bus_cs    = 1'b0;
    bus_wn    = 1'b1;
    bus_addr  = PIO_DATA;
    bus_wdata = '0;
    if (state_q == StInit) begin
      bus_cs    = 1'b1;
      bus_wn    = 1'b0;
      bus_addr  = PIO_MASK;
      bus_wdata = 32'(mask_shadow_q);
    end else if (state_q == StClr0) begin
      bus_cs   = 1'b1;
      bus_wn   = 1'b0;
      bus_addr = PIO_EDGE;
    end else begin
      unique case (state_d)
        StRdCap: begin
          bus_cs   = 1'b1;
          bus_addr = PIO_EDGE;
        end
        StRdCapW, StRdDat, StRdDatW: begin
          bus_cs   = 1'b1;
          bus_addr = PIO_DATA;
        end
        StClr: begin
          bus_cs   = 1'b1;
          bus_wn   = 1'b0;
          bus_addr = PIO_EDGE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StInit;
      cs_q          <= 1'b0;
      wn_q          <= 1'b1;
      addr_q        <= PIO_DATA;
      wdata_q       <= '0;
      evt_valid_q   <= 1'b0;
      cap_q         <= '0;
      lvl_q         <= '0;
      load_pend_q   <= 1'b0;
      mask_shadow_q <= MASK_RST;
      busy_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      cs_q        <= bus_cs;
      wn_q        <= bus_wn;
      addr_q      <= bus_addr;
      wdata_q     <= bus_wdata;
      evt_valid_q <= (state_d == StPush);
      busy_q      <= (state_d != StIdle);
      load_pend_q <= load_pend_d;
      if (cfg_load)              mask_shadow_q <= cfg_mask;
      if (state_q == StRdCapW)   cap_q         <= pio_readdata[WIDTH-1:0];
      if (state_q == StRdDatW)   lvl_q         <= pio_readdata[WIDTH-1:0];
    end
  end

  assign pio_chipselect = cs_q;
  assign pio_write_n    = wn_q;
  assign pio_address    = addr_q;
  assign pio_writedata  = wdata_q;
  assign evt_valid      = evt_valid_q;
  assign evt_edges      = cap_q;
  assign evt_level      = lvl_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_pio_edge_service_ctrl.sv
// Bench for pio_edge_service_ctrl: behavioural edge-capture PIO plus directed and random checks.
module tb_pio_edge_service_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  cfg_mask = '0;
  logic        cfg_load = 1'b0;
  logic        pio_irq;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic [31:0] pio_readdata = '0;
  logic        evt_valid;
  logic        evt_ready = 1'b0;
  logic [9:0]  evt_edges;
  logic [9:0]  evt_level;
  logic        busy;
  logic        force_irq = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pio_edge_service_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_mask       (cfg_mask),
    .cfg_load       (cfg_load),
    .pio_irq        (pio_irq),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata),
    .pio_readdata   (pio_readdata),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_edges      (evt_edges),
    .evt_level      (evt_level),
    .busy           (busy)
  );

  // Edge-capturing PIO: two-flop edge detect, capture enabled by irq_mask, any write to 3 clears.
  logic [9:0] in_port = '0;
  logic [9:0] sync1 = '0, sync2 = '0;
  logic [9:0] pio_mask = '0, pio_cap = '0;

  assign pio_irq = (|(pio_cap & pio_mask)) | force_irq;

  always @(posedge clk) begin
    sync1 <= in_port;
    sync2 <= sync1;
    if (pio_chipselect && !pio_write_n && pio_address == 2'd2) pio_mask <= pio_writedata[9:0];
    if (pio_chipselect && !pio_write_n && pio_address == 2'd3) pio_cap <= '0;
    else pio_cap <= pio_cap | ((sync1 ^ sync2) & pio_mask);
    case (pio_address)
      2'd0:    pio_readdata <= {22'd0, in_port};
      2'd2:    pio_readdata <= {22'd0, pio_mask};
      2'd3:    pio_readdata <= {22'd0, pio_cap};
      default: pio_readdata <= '0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cs"}, pio_chipselect, 1'b0);
    check_eq({tag, "_wn"}, pio_write_n, 1'b1);
    check_eq({tag, "_addr"}, pio_address, 2'd0);
    check_eq({tag, "_wdata"}, pio_writedata, 32'd0);
    check_eq({tag, "_valid"}, evt_valid, 1'b0);
    check_eq({tag, "_edges"}, evt_edges, 10'd0);
    check_eq({tag, "_level"}, evt_level, 10'd0);
    check_eq({tag, "_busy"}, busy, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || pio_irq) && n < 60) begin
      tick();
      n++;
    end
    check_eq({tag, "_idle"}, (n < 60), 1'b1);
    tick();
    tick();
  endtask

  // Wait for an event, hold it off for 'hold' cycles (toggling 'tog' midway), then accept it.
  task automatic accept_event(input string tag, input logic [9:0] ee, input logic [9:0] el,
                              input int hold, input logic [9:0] tog);
    int n = 0;
    int unstable = 0;
    logic [9:0] e0, l0;
    while (!evt_valid && n < 40) begin
      tick();
      n++;
    end
    check_eq({tag, "_valid"}, evt_valid, 1'b1);
    e0 = evt_edges;
    l0 = evt_level;
    for (int i = 0; i < hold; i++) begin
      if (i == hold / 2) in_port ^= tog;
      tick();
      if (!evt_valid || evt_edges !== e0 || evt_level !== l0) unstable++;
    end
    if (hold > 0) check_eq({tag, "_stable"}, unstable, 0);
    check_eq({tag, "_edges"}, evt_edges, ee);
    check_eq({tag, "_level"}, evt_level, el);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    check_eq({tag, "_drop"}, evt_valid, 1'b0);
  endtask

  initial begin
    int n, lat, hold;
    logic [9:0] delta, tog, lvl;
    logic saw_clr, saw_valid;

    // Reset state and INIT/CLR0 sequence
    repeat (3) tick();
    check_reset_outputs("rst");
    reset = 1'b0;
    tick();
    check_eq("init_cs", pio_chipselect, 1'b1);
    check_eq("init_wn", pio_write_n, 1'b0);
    check_eq("init_addr", pio_address, 2'd2);
    check_eq("init_wdata", pio_writedata, 32'h3FF);
    tick();
    check_eq("clr0_wn", pio_write_n, 1'b0);
    check_eq("clr0_addr", pio_address, 2'd3);
    tick();
    check_eq("settle_cs", pio_chipselect, 1'b0);
    check_eq("busy_low_c3", busy, 1'b0);
    check_eq("init_no_evt", evt_valid, 1'b0);
    repeat (3) tick();

    // First event and irq-to-valid latency
    evt_ready = 1'b1;
    in_port = 10'h005;
    n = 0;
    while (!(pio_irq && !busy) && n < 20) begin
      tick();
      n++;
    end
    check_eq("irq_seen", (n < 20), 1'b1);
    lat = 0;
    while (!evt_valid && lat < 20) begin
      tick();
      lat++;
    end
    check_eq("latency", lat, 6);
    check_eq("ev1_edges", evt_edges, 10'h005);
    check_eq("ev1_level", evt_level, 10'h005);
    tick();
    check_eq("ev1_drop", evt_valid, 1'b0);
    tick();
    tick();
    check_eq("ev1_irq_low", pio_irq, 1'b0);
    check_eq("ev1_idle", busy, 1'b0);
    evt_ready = 1'b0;
    tick();

    // Backpressure: held event stays stable while bit 9 toggles; it arrives afterwards
    in_port ^= 10'h002;
    accept_event("bp", 10'h002, 10'h007, 20, 10'h200);
    accept_event("bp2", 10'h200, 10'h207, 0, 10'h000);
    wait_idle("bp");

    // Random toggles with random hold-off and toggles during hold-off
    for (int k = 0; k < 40; k++) begin
      delta = 10'($urandom_range(1, 1023));
      in_port ^= delta;
      lvl = in_port;
      hold = int'($urandom_range(0, 6));
      tog = (hold > 0 && $urandom_range(0, 1) == 1) ? 10'($urandom_range(1, 1023)) : 10'd0;
      accept_event("rnd", delta, lvl, hold, tog);
      if (tog != 10'd0) accept_event("rnd2", tog, in_port, int'($urandom_range(0, 3)), 10'd0);
      wait_idle("rnd");
    end

    // Mask reprogram: only bit 0 may raise events
    cfg_mask = 10'h001;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    wait_idle("cfg");
    check_eq("cfg_pio_mask", pio_mask, 10'h001);
    in_port ^= 10'h010;
    saw_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      saw_valid |= evt_valid | busy;
    end
    check_eq("mask_bit4_quiet", saw_valid, 1'b0);
    in_port ^= 10'h001;
    accept_event("mask", 10'h001, in_port, 2, 10'h000);
    wait_idle("mask");

    // Spurious irq: clear write happens, no event
    force_irq = 1'b1;
    tick();
    force_irq = 1'b0;
    saw_clr = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (pio_chipselect && !pio_write_n && pio_address == 2'd3) saw_clr = 1'b1;
      saw_valid |= evt_valid;
    end
    check_eq("spur_clr", saw_clr, 1'b1);
    check_eq("spur_no_evt", saw_valid, 1'b0);
    check_eq("spur_idle", busy, 1'b0);

    // Reset during RDDAT abandons the transaction
    in_port ^= 10'h001;
    n = 0;
    while (!(pio_irq && !busy) && n < 20) begin
      tick();
      n++;
    end
    check_eq("rrst_irq_seen", (n < 20), 1'b1);
    repeat (3) tick();
    check_eq("rrst_rddat_addr", pio_address, 2'd0);
    check_eq("rrst_rddat_cs", pio_chipselect, 1'b1);
    reset = 1'b1;
    tick();
    check_reset_outputs("rrst");
    reset = 1'b0;
    tick();
    check_eq("rrst_init_addr", pio_address, 2'd2);
    check_eq("rrst_init_wdata", pio_writedata, 32'h3FF);
    saw_valid = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      saw_valid |= evt_valid;
    end
    check_eq("rrst_no_evt", saw_valid, 1'b0);
    check_eq("rrst_idle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
